gpio_led_ctrl: RTL and testbench
================================

# gpio_led_ctrl

Downstream consumer of the 16-bit GPIO output word produced by the wishbone_communication block. It replaces the direct `gpio[1:0]`-to-LED wiring with a small LED engine that supports four output modes: static, blink, PWM dimming and breathing. All four modes are controlled entirely by fields of that GPIO word. It runs on the board oscillator and drives the two board LEDs.

## Interface
Parameters:
- PRESCALE, 4: oscillator clocks per PWM tick (≥1).
- BLINK_BASE, 16: log2 of the blink half-period at rate 0.

Ports:
- OSC_FPGA  input  1  system clock; GPIO_IN is synchronous to it.
- RST  input  1  asynchronous, active-high reset.
- GPIO_IN  input  16  control word from wishbone_communication GPIO_OUT.
- LED  output  2  LED drive, active-high, registered.

Control word fields:
- [1:0] EN: per-LED enable.
- [3:2] MODE: 0 = static, 1 = blink, 2 = PWM, 3 = breathe.
- [7:4] RATE: blink rate select.
- [15:8] DUTY: PWM duty, 0–255.

## Operation
- **Input register.** GPIO_IN is registered into `ctl` every clock. All logic uses `ctl`.
- **Prescaler.** `pre_cnt` counts 0..PRESCALE-1 and wraps. `tick` = (pre_cnt == PRESCALE-1).
- **PWM counter.** `pwm_cnt` (8 bits) increments on `tick` and wraps 255→0. `frame_end` = tick && pwm_cnt == 255. One frame = 256·PRESCALE clocks.
- **Blink counter.** `blink_cnt` (BLINK_BASE+16 bits) is free-running. `phase` = blink_cnt[BLINK_BASE+RATE].
- **Breathe state.** Registers `bre_duty` (8 bits) and `dir` (0 = up), updated only on `frame_end`:
  - dir up: bre_duty+1; when bre_duty reaches 255, dir becomes down.
  - dir down: bre_duty−1; when bre_duty reaches 0, dir becomes up.
  - Triangle 0→255→0; the 255 and 0 end points each last one frame.
- **Pattern `pat`** (one bit, shared by both LEDs):
  - static: 1
  - blink: phase
  - PWM: pwm_cnt < DUTY
  - breathe: pwm_cnt < bre_duty
- **LED output.** Registered: LED[i] ← EN[i] & pat.
- **Mode change.** When ctl.MODE differs from its previous registered value, clear blink_cnt, bre_duty and dir, starting each mode at the dark phase. pre_cnt and pwm_cnt are never cleared except by reset.
- **Unaffected fields.** Changes to DUTY, RATE or EN take effect immediately and reset nothing.

## Timing
- **Reset.** RST asynchronously clears ctl, the previous-MODE register, pre_cnt, pwm_cnt, blink_cnt, bre_duty and dir. LED = 00 while RST is high and until the first pattern evaluation after release.
- **Latency.**
  - GPIO_IN change → ctl: 1 clock.
  - ctl → LED: 1 clock.
  - Static mode: LED follows GPIO_IN[1:0] on the 2nd rising edge after the change.
- **Duty boundaries.**
  - DUTY = 0: LED never on.
  - DUTY = 255: on 255 of 256 ticks.
  - bre_duty = 0: dark frame.
- **Blink half-period.** 2^(BLINK_BASE+RATE) clocks.
  - A RATE change mid-period switches to the new bit; a phase jump is permitted.
  - blink_cnt wraps silently at full width.
- **Mode change and frame_end on the same clock.** The clear wins; bre_duty = 0.
- **Reset mid-operation.** LED forced to 00 immediately, with no clock required. All counters restart from 0.

## Test plan
Bench parameters: PRESCALE=2, BLINK_BASE=2.

1. **Reset.** RST high, GPIO_IN=0xFFFF toggling → LED=00 throughout. Release RST with GPIO_IN=0x0000 → LED stays 00.
2. **Static.** GPIO_IN 0x0000→0x0003 → LED=11 exactly at the 2nd edge after the change. Then 0x0002 → LED=10 two edges later.
3. **PWM.** GPIO_IN=0x400A (EN=10, MODE=2, DUTY=0x40) → LED[1] high 128 of every 512 clocks, one contiguous run per frame; LED[0]=0. Then DUTY=0x00 → LED=00 permanently.
4. **Blink.** GPIO_IN=0x0017 (EN=11, MODE=1, RATE=1) → after mode entry, LED=00 for 8 clocks, then alternates 11/00 every 8 clocks. Then RATE=0 → half-period 4 clocks.
5. **Breathe.** GPIO_IN=0x000D → frame k (512 clocks each) has LED[0] on for 2·bre_duty clocks: 0,2,4,…,510 (frame 255), then 508,…,0, then rising again.
6. **Async reset mid-blink.** Assert RST between clock edges during LED=11 → LED=00 with no clock edge. After release, the blink restarts from the dark phase.

Source files
------------

// File: rtl/gpio_led_ctrl_if.sv
// GPIO control word in, LED drive out, between wishbone_communication and the LED engine.
interface gpio_led_ctrl_if;
  logic [15:0] GPIO_IN;
  logic [1:0]  LED;

  modport master (output GPIO_IN, input LED);
  modport slave  (input GPIO_IN, output LED);
endinterface

// File: rtl/gpio_led_ctrl.sv
// LED engine for the two board LEDs: static, blink, PWM dimming and breathing modes,
// all selected by fields of the 16-bit GPIO control word.
module gpio_led_ctrl #(
  parameter int unsigned PRESCALE   = 4,
  parameter int unsigned BLINK_BASE = 16
) (
  input  logic           OSC_FPGA,
  input  logic           RST,
  gpio_led_ctrl_if.slave gpio
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned BLK_W = BLINK_BASE + 16;

  typedef enum logic [1:0] {
    MODE_STATIC  = 2'd0,
    MODE_BLINK   = 2'd1,
    MODE_PWM     = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  logic [15:0]      ctl;
  mode_t            mode_prev;
  logic [PRE_W-1:0] pre_cnt;
  logic [7:0]       pwm_cnt;
  logic [BLK_W-1:0] blink_cnt;
  logic [BLK_W-1:0] blink_shift;
  logic [7:0]       bre_duty;
  dir_t             dir;
  logic [1:0]       led_q;

  logic [1:0] ctl_en;
  mode_t      ctl_mode;
  logic [3:0] ctl_rate;
  logic [7:0] ctl_duty;
  logic       mode_chg;
  logic       tick;
  logic       frame_end;
  logic       phase;
  logic       pat;

  assign ctl_en    = ctl[1:0];
  assign ctl_mode  = mode_t'(ctl[3:2]);
  assign ctl_rate  = ctl[7:4];
  assign ctl_duty  = ctl[15:8];
  assign mode_chg  = (ctl_mode != mode_prev);
  assign tick      = (pre_cnt == PRE_W'(PRESCALE - 1));
  assign frame_end = tick && (pwm_cnt == 8'hFF);

  assign blink_shift = blink_cnt >> ctl_rate;
  assign phase       = blink_shift[BLINK_BASE];

  assign gpio.LED = led_q;

  always_ff @(posedge OSC_FPGA or posedge RST) begin
    if (RST) begin
      ctl       <= '0;
      mode_prev <= MODE_STATIC;
    end else begin
      ctl       <= gpio.GPIO_IN;
      mode_prev <= ctl_mode;
    end
  end

  always_ff @(posedge OSC_FPGA or posedge RST) begin
    if (RST) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
      pwm_cnt <= pwm_cnt + 8'd1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  always_ff @(posedge OSC_FPGA or posedge RST) begin
    if (RST) begin
      blink_cnt <= '0;
    end else if (mode_chg) begin
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Triangle 0..255..0; turning on 254/1 makes each end point last exactly one frame.
  always_ff @(posedge OSC_FPGA or posedge RST) begin
    if (RST) begin
      bre_duty <= '0;
      dir      <= DIR_UP;
    end else if (mode_chg) begin
      bre_duty <= '0;
      dir      <= DIR_UP;
    end else if (frame_end) begin
      if (dir == DIR_UP) begin
        bre_duty <= bre_duty + 8'd1;
        if (bre_duty == 8'd254) dir <= DIR_DOWN;
      end else begin
        bre_duty <= bre_duty - 8'd1;
        if (bre_duty == 8'd1) dir <= DIR_UP;
      end
    end
  end

  // On the mode-change clock the stale blink/breathe state is still visible; hold it dark
  // so the new mode really starts from its dark phase.
  always_comb begin
    pat = 1'b0;
    unique case (ctl_mode)
      MODE_STATIC:  pat = 1'b1;
      MODE_BLINK:   pat = phase && !mode_chg;
      MODE_PWM:     pat = (pwm_cnt < ctl_duty);
      MODE_BREATHE: pat = (pwm_cnt < bre_duty) && !mode_chg;
      default:      pat = 1'b0;
    endcase
  end

  always_ff @(posedge OSC_FPGA or posedge RST) begin
    if (RST) begin
      led_q <= '0;
    end else begin
      led_q <= ctl_en & {2{pat}};
    end
  end

endmodule

// File: tb/tb_gpio_led_ctrl.sv
// Randomized directed bench for gpio_led_ctrl against a closed-form model of the LED engine.
module tb_gpio_led_ctrl;

  localparam int unsigned P  = 2;
  localparam int unsigned BB = 2;
  localparam int unsigned FRAME = 256 * P;

  logic clk;
  logic rst;
  gpio_led_ctrl_if bus ();

  gpio_led_ctrl #(.PRESCALE(P), .BLINK_BASE(BB)) dut (
    .OSC_FPGA (clk),
    .RST      (rst),
    .gpio     (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Model state: edges since reset release, edge of the last clear, registered word, prior mode.
  int unsigned m_n;
  int unsigned m_c;
  logic [15:0] m_ctl;
  logic [1:0]  m_prev;
  logic [1:0]  last_exp;

  task automatic mreset();
    m_n    = 0;
    m_c    = 0;
    m_ctl  = '0;
    m_prev = '0;
  endtask

  function automatic logic [1:0] model_led();
    int unsigned t, pwm, v, k, r, bd;
    logic chg, ph, pat;
    t   = m_n;
    chg = (m_ctl[3:2] != m_prev);
    pwm = (t / P) % 256;
    v   = (t - m_c) % (1 << (BB + 16));
    ph  = ((v >> (BB + int'(m_ctl[7:4]))) & 1) != 0;
    k   = t / FRAME - m_c / FRAME;
    r   = k % 510;
    bd  = (r <= 255) ? r : 510 - r;
    case (m_ctl[3:2])
      2'd0:    pat = 1'b1;
      2'd1:    pat = ph && !chg;
      2'd2:    pat = pwm < int'(m_ctl[15:8]);
      default: pat = (pwm < bd) && !chg;
    endcase
    return m_ctl[1:0] & {pat, pat};
  endfunction

  task automatic check(input string tag, input logic [1:0] exp);
    n_cmp++;
    assert (bus.LED === exp)
    else begin
      n_bad++;
      $error("FAIL %s: LED observed %b expected %b (edge %0d)", tag, bus.LED, exp, m_n);
    end
  endtask

  task automatic cyc(input logic [15:0] g, input string tag);
    logic chg;
    last_exp = model_led();
    chg = (m_ctl[3:2] != m_prev);
    bus.GPIO_IN = g;
    @(posedge clk);
    #1;
    m_n++;
    if (chg) m_c = m_n;
    m_prev = m_ctl[3:2];
    m_ctl  = g;
    check(tag, last_exp);
  endtask

  task automatic hold(input logic [15:0] g, input int unsigned cycles, input string tag);
    for (int unsigned i = 0; i < cycles; i++) cyc(g, tag);
  endtask

  initial begin
    logic [15:0] w;
    bit found;

    // Reset held with a toggling word: LED must stay dark.
    rst = 1'b1;
    bus.GPIO_IN = 16'hFFFF;
    #2;
    check("reset_async", 2'b00);
    for (int i = 0; i < 8; i++) begin
      bus.GPIO_IN = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
      @(posedge clk);
      #1;
      check("reset_hold", 2'b00);
    end
    bus.GPIO_IN = 16'h0000;
    #2 rst = 1'b0;
    mreset();
    hold(16'h0000, 5, "reset_release");

    // Static mode, including explicit 2nd-edge latency.
    cyc(16'h0003, "static_e1");
    check("static_e1_old", 2'b00);
    cyc(16'h0003, "static_e2");
    check("static_e2_new", 2'b11);
    hold(16'h0003, 3, "static_11");
    cyc(16'h0002, "static_e1b");
    cyc(16'h0002, "static_e2b");
    check("static_10", 2'b10);
    for (int i = 0; i < 12; i++) begin
      w = 16'($urandom) & 16'hFFF3;
      hold(w, $urandom_range(1, 4), "static_rand");
    end

    // PWM: two full frames at DUTY=0x40, then boundary and random duties.
    hold(16'h400A, 2 * FRAME + 20, "pwm_40");
    hold(16'h000A, FRAME + 10, "pwm_duty0");
    hold(16'hFF0B, FRAME + 10, "pwm_duty255");
    for (int i = 0; i < 6; i++) begin
      w = {8'($urandom), 4'($urandom), 2'b10, 2'($urandom)};
      hold(w, $urandom_range(50, 400), "pwm_rand");
    end

    // Blink: RATE=1 then RATE=0, then random small rates.
    hold(16'h0017, 80, "blink_r1");
    hold(16'h0007, 40, "blink_r0");
    for (int i = 0; i < 8; i++) begin
      w = {8'($urandom), 4'($urandom_range(0, 3)), 2'b01, 2'($urandom)};
      hold(w, $urandom_range(10, 90), "blink_rand");
    end

    // Breathe from mode entry over the first rising frames.
    hold(16'h0000, 3, "pre_breathe");
    hold(16'h000D, 24 * FRAME, "breathe");

    // Random words with random hold times, exercising mode changes everywhere.
    for (int i = 0; i < 80; i++) begin
      w = 16'($urandom);
      hold(w, $urandom_range(1, 60), "mixed_rand");
    end

    // Async reset mid-blink while the LEDs are lit.
    hold(16'h0000, 2, "pre_blink_rst");
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cyc(16'h0017, "blink_wait_on");
      if (last_exp == 2'b11) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL blink_on_timeout: LED observed %b expected 11 within 100 clocks", bus.LED);
    end
    #2 rst = 1'b1;
    #1;
    check("async_rst_noclk", 2'b00);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("async_rst_hold", 2'b00);
    end
    #2 rst = 1'b0;
    mreset();
    hold(16'h0017, 60, "blink_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
